// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// Each transaction is latched, replayed onto the single memory port, and completed with one done pulse.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // One extra bit so the counter can reach RD_LAT without wrapping.
    localparam int CNT_W = $clog2(RD_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              owner;
    logic              last;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              arb_valid;
    logic              arb_owner;
    logic              xfer_end;
    logic              accept;
    logic              rd_capture;

    // On a tie the port that was not granted last time wins.
    always_comb begin
        arb_valid = r0_req | r1_req;
        arb_owner = (r0_req & r1_req) ? ~last : r1_req;
    end

    always_comb begin
        xfer_end   = lat_we | (cnt == CNT_LAST);
        accept     = (state == IDLE) & arb_valid;
        rd_capture = (state == XFER) & ~lat_we & (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (xfer_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            owner     <= arb_owner;
            last      <= arb_owner;
            lat_we    <= arb_owner ? r1_we    : r0_we;
            lat_addr  <= arb_owner ? r1_addr  : r0_addr;
            lat_wdata <= arb_owner ? r1_wdata : r0_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == XFER) && !lat_we) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Read data is only ever written by the owning port's read completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (rd_capture) begin
            if (owner) begin
                rdata1_q <= mem_rdata;
            end else begin
                rdata0_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_we    = (state == XFER) &  lat_we;
        mem_re    = (state == XFER) & ~lat_we;
        busy      = (state != IDLE);
        r0_gnt    = ((state == XFER) || (state == DONE)) & ~owner;
        r1_gnt    = ((state == XFER) || (state == DONE)) &  owner;
        r0_done   = (state == DONE) & ~owner;
        r1_done   = (state == DONE) &  owner;
        r0_rdata  = rdata0_q;
        r1_rdata  = rdata1_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter; instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
module tb_dmem_arbiter;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst;

    logic        r0_req   [2];
    logic        r0_we    [2];
    logic [31:0] r0_addr  [2];
    logic [31:0] r0_wdata [2];
    logic        r0_gnt   [2];
    logic        r0_done  [2];
    logic [31:0] r0_rdata [2];
    logic        r1_req   [2];
    logic        r1_we    [2];
    logic [31:0] r1_addr  [2];
    logic [31:0] r1_wdata [2];
    logic        r1_gnt   [2];
    logic        r1_done  [2];
    logic [31:0] r1_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic        mem_we   [2];
    logic        mem_re   [2];
    logic [31:0] mem_rdata[2];
    logic        busy     [2];

    int checks   = 0;
    int failures = 0;
    int done_cnt [2];
    sb_t sbq0[$];
    sb_t sbq1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram [256];

        dmem_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .RD_LAT((g == 0) ? 1 : 3)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .r0_req   (r0_req[g]),
            .r0_we    (r0_we[g]),
            .r0_addr  (r0_addr[g]),
            .r0_wdata (r0_wdata[g]),
            .r0_gnt   (r0_gnt[g]),
            .r0_done  (r0_done[g]),
            .r0_rdata (r0_rdata[g]),
            .r1_req   (r1_req[g]),
            .r1_we    (r1_we[g]),
            .r1_addr  (r1_addr[g]),
            .r1_wdata (r1_wdata[g]),
            .r1_gnt   (r1_gnt[g]),
            .r1_done  (r1_done[g]),
            .r1_rdata (r1_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_we   (mem_we[g]),
            .mem_re   (mem_re[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );

        // Combinational RAM model; address is stable through XFER so any latency sees the same word.
        assign mem_rdata[g] = ram[mem_addr[g][7:0]];

        always @(posedge clk) begin
            if (rst) begin
                ram[8'h10] <= 32'h0000_1234;
            end else if (mem_we[g]) begin
                ram[mem_addr[g][7:0]] <= mem_wdata[g];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input int p, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] data);
        if (p == 0) begin
            r0_req[i] = req; r0_we[i] = we; r0_addr[i] = addr; r0_wdata[i] = data;
        end else begin
            r1_req[i] = req; r1_we[i] = we; r1_addr[i] = addr; r1_wdata[i] = data;
        end
    endtask

    task automatic sbPush(input int i, input int p, input logic we, input logic [31:0] data);
        sb_t e;
        e.port = p; e.we = we; e.data = data;
        if (i == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    task automatic sbPop(input int i, input int p);
        sb_t e;
        int  sz;
        sz = (i == 0) ? sbq0.size() : sbq1.size();
        checkOutput($sformatf("sb_pending_i%0d_p%0d", i, p), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
            checkOutput($sformatf("grant_order_i%0d", i), 64'(p), 64'(e.port));
            checkOutput($sformatf("gnt_at_done_i%0d_p%0d", i, p),
                        64'((p == 0) ? r0_gnt[i] : r1_gnt[i]), 64'd1);
            if (!e.we) begin
                checkOutput($sformatf("rdata_i%0d_p%0d", i, p),
                            64'((p == 0) ? r0_rdata[i] : r1_rdata[i]), 64'(e.data));
            end
        end
        done_cnt[i]++;
    endtask

    // Completion monitor: every done pulse consumes exactly one expected transaction.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (r0_done[i]) sbPop(i, 0);
                if (r1_done[i]) sbPop(i, 1);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input int i, input string tag);
        checkOutput({tag, "_mem_addr"},  64'(mem_addr[i]),  64'd0);
        checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata[i]), 64'd0);
        checkOutput({tag, "_mem_we"},    64'(mem_we[i]),    64'd0);
        checkOutput({tag, "_mem_re"},    64'(mem_re[i]),    64'd0);
        checkOutput({tag, "_gnt"},       64'({r0_gnt[i], r1_gnt[i]}),   64'd0);
        checkOutput({tag, "_done"},      64'({r0_done[i], r1_done[i]}), 64'd0);
        checkOutput({tag, "_r0_rdata"},  64'(r0_rdata[i]),  64'd0);
        checkOutput({tag, "_r1_rdata"},  64'(r1_rdata[i]),  64'd0);
        checkOutput({tag, "_busy"},      64'(busy[i]),      64'd0);
    endtask

    initial begin
        int base;
        int n;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        rst = 1'b1;

        // Reset with random inputs: every output must read zero.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                applyStimulus(i, 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
                applyStimulus(i, 1, 1'($urandom), 1'($urandom), $urandom, $urandom);
            end
            #7;
            checkIdle(0, $sformatf("rst%0d_i0", k));
            checkIdle(1, $sformatf("rst%0d_i1", k));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
            applyStimulus(i, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        next();
        rst = 1'b0;
        next();
        next();
        checkIdle(0, "post_rst_i0");
        checkIdle(1, "post_rst_i1");

        $display("[TB] write then read, RD_LAT=1");
        applyStimulus(0, 0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        sbPush(0, 0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("wr_c0_mem_we", 64'(mem_we[0]), 64'd0);
        next();
        checkOutput("wr_c1_mem_we",    64'(mem_we[0]),    64'd1);
        checkOutput("wr_c1_mem_re",    64'(mem_re[0]),    64'd0);
        checkOutput("wr_c1_mem_addr",  64'(mem_addr[0]),  64'd5);
        checkOutput("wr_c1_mem_wdata", 64'(mem_wdata[0]), 64'hDEAD_BEEF);
        checkOutput("wr_c1_r0_gnt",    64'(r0_gnt[0]),    64'd1);
        checkOutput("wr_c1_r0_done",   64'(r0_done[0]),   64'd0);
        next();
        checkOutput("wr_c2_r0_done", 64'(r0_done[0]), 64'd1);
        checkOutput("wr_c2_mem_we",  64'(mem_we[0]),  64'd0);
        applyStimulus(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        next();
        checkOutput("wr_c3_busy", 64'(busy[0]), 64'd0);

        applyStimulus(0, 0, 1'b1, 1'b0, 32'd5, 32'd0);
        sbPush(0, 0, 1'b0, 32'hDEAD_BEEF);
        next();
        checkOutput("rd_c1_mem_re", 64'(mem_re[0]), 64'd1);
        checkOutput("rd_c1_mem_we", 64'(mem_we[0]), 64'd0);
        next();
        checkOutput("rd_c2_r0_done",  64'(r0_done[0]),  64'd1);
        checkOutput("rd_c2_r0_rdata", 64'(r0_rdata[0]), 64'hDEAD_BEEF);
        checkOutput("rd_c2_r1_rdata", 64'(r1_rdata[0]), 64'd0);
        applyStimulus(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        next();

        $display("[TB] contention from reset");
        rst = 1'b1;
        applyStimulus(0, 0, 1'b1, 1'b1, 32'h20, 32'hA5A5_0001);
        applyStimulus(0, 1, 1'b1, 1'b0, 32'h20, 32'd0);
        sbPush(0, 0, 1'b1, 32'hA5A5_0001);
        sbPush(0, 1, 1'b0, 32'hA5A5_0001);
        sbPush(0, 0, 1'b1, 32'hA5A5_0001);
        sbPush(0, 1, 1'b0, 32'hA5A5_0001);
        next();
        rst = 1'b0;
        base = done_cnt[0];
        n = 0;
        while ((done_cnt[0] < base + 4) && (n < 40)) begin
            next();
            n++;
        end
        applyStimulus(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("contention_done_count", 64'(done_cnt[0] - base), 64'd4);
        checkOutput("contention_cycles",     64'(n),                  64'd12);
        next();
        next();
        checkOutput("contention_sb_drained", 64'(sbq0.size()), 64'd0);
        checkOutput("contention_idle",       64'(busy[0]),     64'd0);

        $display("[TB] RD_LAT=3 read on port 1");
        applyStimulus(1, 1, 1'b1, 1'b0, 32'h10, 32'd0);
        sbPush(1, 1, 1'b0, 32'h0000_1234);
        for (int c = 1; c <= 3; c++) begin
            next();
            checkOutput($sformatf("lat3_c%0d_mem_re", c),  64'(mem_re[1]),  64'd1);
            checkOutput($sformatf("lat3_c%0d_r1_done", c), 64'(r1_done[1]), 64'd0);
            checkOutput($sformatf("lat3_c%0d_r1_gnt", c),  64'(r1_gnt[1]),  64'd1);
        end
        next();
        checkOutput("lat3_c4_r1_done",  64'(r1_done[1]),  64'd1);
        checkOutput("lat3_c4_mem_re",   64'(mem_re[1]),   64'd0);
        checkOutput("lat3_c4_r1_rdata", 64'(r1_rdata[1]), 64'h0000_1234);
        checkOutput("lat3_c4_r0_rdata", 64'(r0_rdata[1]), 64'd0);
        applyStimulus(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        next();

        $display("[TB] reset during a write");
        applyStimulus(0, 0, 1'b1, 1'b1, 32'd7, 32'h5555_AAAA);
        sbPush(0, 0, 1'b1, 32'h5555_AAAA);
        next();
        checkOutput("mid_rst_pre_mem_we", 64'(mem_we[0]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_mem_we", 64'(mem_we[0]), 64'd0);
        checkOutput("mid_rst_busy",   64'(busy[0]),   64'd0);
        checkOutput("mid_rst_r0_gnt", 64'(r0_gnt[0]), 64'd0);
        sbq0.delete();
        base = done_cnt[0];
        next();
        checkOutput("mid_rst_no_done", 64'(done_cnt[0] - base), 64'd0);
        rst = 1'b0;
        sbPush(0, 0, 1'b1, 32'h5555_AAAA);
        next();
        checkOutput("rerq_c1_mem_we",   64'(mem_we[0]),   64'd1);
        checkOutput("rerq_c1_mem_addr", 64'(mem_addr[0]), 64'd7);
        next();
        checkOutput("rerq_c2_r0_done", 64'(r0_done[0]), 64'd1);
        applyStimulus(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        next();
        checkOutput("rerq_ram_word", 64'(g_dut[0].ram[7]), 64'h5555_AAAA);

        $display("[TB] late arrival on port 1");
        applyStimulus(0, 0, 1'b1, 1'b0, 32'h20, 32'd0);
        sbPush(0, 0, 1'b0, 32'hA5A5_0001);
        next();
        applyStimulus(0, 1, 1'b1, 1'b0, 32'd5, 32'd0);
        sbPush(0, 1, 1'b0, 32'hDEAD_BEEF);
        checkOutput("late_c1_r0_gnt", 64'(r0_gnt[0]), 64'd1);
        next();
        checkOutput("late_c2_r0_done", 64'(r0_done[0]), 64'd1);
        checkOutput("late_c2_r1_gnt",  64'(r1_gnt[0]),  64'd0);
        applyStimulus(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        next();
        checkOutput("late_c3_busy",   64'(busy[0]),   64'd0);
        checkOutput("late_c3_r1_gnt", 64'(r1_gnt[0]), 64'd0);
        next();
        checkOutput("late_c4_r1_gnt", 64'(r1_gnt[0]), 64'd1);
        next();
        checkOutput("late_c5_r1_done", 64'(r1_done[0]), 64'd1);
        applyStimulus(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        next();
        next();

        checkOutput("final_sb0_drained", 64'(sbq0.size()), 64'd0);
        checkOutput("final_sb1_drained", 64'(sbq1.size()), 64'd0);
        checkOutput("final_busy0",       64'(busy[0]),     64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
